// File: rtl/time_date_counter_pkg.sv
// time_date_counter_pkg
// Shared definitions for the time/date counter: field widths, calendar
// limits, the set-handling FSM state encoding, the packed time record and
// the days_in_month helper used both for rollover and for set validation.
package time_date_counter_pkg;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;
  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_W  = 12;

  localparam logic [SEC_W-1:0]   SEC_MAX   = 6'd59;
  localparam logic [MIN_W-1:0]   MIN_MAX   = 6'd59;
  localparam logic [HOUR_W-1:0]  HOUR_MAX  = 5'd23;
  localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd12;
  localparam logic [YEAR_W-1:0]  YEAR_MIN  = 12'd2000;
  localparam logic [YEAR_W-1:0]  YEAR_MAX  = 12'd2099;

  // Set-handling FSM: IDLE accepts a request, CHECK validates the staged copy.
  localparam int STATE_W = 1;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  typedef struct packed {
    logic [YEAR_W-1:0]  year;
    logic [MONTH_W-1:0] month;
    logic [DAY_W-1:0]   day;
    logic [HOUR_W-1:0]  hour;
    logic [MIN_W-1:0]   minute;
    logic [SEC_W-1:0]   second;
  } time_t;

  // Leap rule "divisible by 4" is exact for 2000..2099 (2000 is a leap year).
  function automatic logic [DAY_W-1:0] days_in_month(
    input logic [MONTH_W-1:0] month,
    input logic [YEAR_W-1:0]  year
  );
    logic [DAY_W-1:0] dim;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = ((year % 12'd4) == 12'd0) ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/time_date_counter_prescaler.sv
// tick_prescaler
// Divides clk down to a one-cycle tick per CLK_FREQ_HZ enabled cycles.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (count -> 0)
//   en    - count enable; count holds while low
//   clr   - synchronous clear to 0, wins over en
//   tick  - high during the cycle the count sits at CLK_FREQ_HZ-1 with en=1
module tick_prescaler #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_FREQ_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
    end
  end

  assign tick = en && (r_count == LAST);

endmodule

// File: rtl/time_date_counter.sv
// time_date_counter
// Binary wall-clock/calendar counter (2000-01-01 .. 2099-12-31) with a
// validated set port.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   en                  - run enable for prescaler and counters
//   set_valid/set_ready - set request handshake
//   set_sec..set_year   - requested time/date fields
//   seconds..year       - registered current time/date
//   sec_pulse           - one-cycle strobe with every seconds advance
//   set_err             - one-cycle strobe when a staged set is rejected
//   dbg_state           - current set-handling FSM state
//
// Handshake: a set is accepted on a rising edge where set_valid and
// set_ready are both high; set_ready is high only in IDLE, so field changes
// while it is low are ignored and a held request is taken again next IDLE.
module time_date_counter
  import time_date_counter_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               set_valid,
  output logic               set_ready,
  input  logic [SEC_W-1:0]   set_sec,
  input  logic [MIN_W-1:0]   set_min,
  input  logic [HOUR_W-1:0]  set_hour,
  input  logic [DAY_W-1:0]   set_day,
  input  logic [MONTH_W-1:0] set_month,
  input  logic [YEAR_W-1:0]  set_year,
  output logic [SEC_W-1:0]   seconds,
  output logic [MIN_W-1:0]   minutes,
  output logic [HOUR_W-1:0]  hours,
  output logic [DAY_W-1:0]   day,
  output logic [MONTH_W-1:0] month,
  output logic [YEAR_W-1:0]  year,
  output logic               sec_pulse,
  output logic               set_err,
  output logic [STATE_W-1:0] dbg_state
);

  state_t r_state;
  state_t w_next_state;
  time_t  r_time;
  time_t  r_stage;
  time_t  w_next_time;

  logic w_tick_raw;
  logic w_tick;
  logic w_accept;
  logic w_load;
  logic w_reject;
  logic w_stage_ok;
  logic [DAY_W-1:0] w_dim;
  logic [DAY_W-1:0] w_stage_dim;

  tick_prescaler #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (w_load),
    .tick (w_tick_raw)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next state. CHECK always lasts exactly one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = ST_CHECK;
      ST_CHECK: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // FSM: outputs. Ticks are dropped while in CHECK (which includes the load
  // edge) so a load never races an increment.
  always_comb begin
    set_ready = (r_state == ST_IDLE);
    w_accept  = set_ready && set_valid;
    w_load    = (r_state == ST_CHECK) && w_stage_ok;
    w_reject  = (r_state == ST_CHECK) && !w_stage_ok;
    w_tick    = w_tick_raw && (r_state == ST_IDLE);
  end

  assign dbg_state = r_state;

  // Staging register: captured on accept, validated during CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else if (w_accept) begin
      r_stage <= '{year: set_year, month: set_month, day: set_day,
                   hour: set_hour, minute: set_min, second: set_sec};
    end
  end

  always_comb begin
    w_stage_dim = days_in_month(r_stage.month, r_stage.year);
    w_stage_ok  = (r_stage.second <= SEC_MAX) &&
                  (r_stage.minute <= MIN_MAX) &&
                  (r_stage.hour   <= HOUR_MAX) &&
                  (r_stage.month  >= 4'd1) && (r_stage.month <= MONTH_MAX) &&
                  (r_stage.day    >= 5'd1) && (r_stage.day   <= w_stage_dim) &&
                  (r_stage.year   >= YEAR_MIN) && (r_stage.year <= YEAR_MAX);
  end

  // One-second advance with the full carry chain resolved in a single cycle.
  always_comb begin
    w_next_time = r_time;
    w_dim       = days_in_month(r_time.month, r_time.year);
    if (r_time.second < SEC_MAX) begin
      w_next_time.second = r_time.second + 6'd1;
    end else begin
      w_next_time.second = '0;
      if (r_time.minute < MIN_MAX) begin
        w_next_time.minute = r_time.minute + 6'd1;
      end else begin
        w_next_time.minute = '0;
        if (r_time.hour < HOUR_MAX) begin
          w_next_time.hour = r_time.hour + 5'd1;
        end else begin
          w_next_time.hour = '0;
          if (r_time.day < w_dim) begin
            w_next_time.day = r_time.day + 5'd1;
          end else begin
            w_next_time.day = 5'd1;
            if (r_time.month < MONTH_MAX) begin
              w_next_time.month = r_time.month + 4'd1;
            end else begin
              w_next_time.month = 4'd1;
              w_next_time.year  = (r_time.year < YEAR_MAX) ?
                                  r_time.year + 12'd1 : YEAR_MIN;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_time    <= '{year: YEAR_MIN, month: 4'd1, day: 5'd1,
                     hour: '0, minute: '0, second: '0};
      sec_pulse <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      if (w_load) begin
        r_time <= r_stage;
      end else if (w_tick) begin
        r_time <= w_next_time;
      end
      sec_pulse <= w_tick;
      set_err   <= w_reject;
    end
  end

  assign seconds = r_time.second;
  assign minutes = r_time.minute;
  assign hours   = r_time.hour;
  assign day     = r_time.day;
  assign month   = r_time.month;
  assign year    = r_time.year;

endmodule

// File: tb/tb_time_date_counter.sv
module tb_time_date_counter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        set_valid = 1'b0;
  logic        set_ready;
  logic [5:0]  set_sec = '0;
  logic [5:0]  set_min = '0;
  logic [4:0]  set_hour = '0;
  logic [4:0]  set_day = '0;
  logic [3:0]  set_month = '0;
  logic [11:0] set_year = '0;
  logic [5:0]  seconds;
  logic [5:0]  minutes;
  logic [4:0]  hours;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [11:0] year;
  logic        sec_pulse;
  logic        set_err;
  logic [0:0]  dbg_state;

  time_date_counter #(.CLK_FREQ_HZ(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .set_valid(set_valid), .set_ready(set_ready),
    .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour),
    .set_day(set_day), .set_month(set_month), .set_year(set_year),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .day(day), .month(month), .year(year),
    .sec_pulse(sec_pulse), .set_err(set_err), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model (calendar arithmetic) ----------------
  int m_year, m_month, m_day, m_hour, m_min, m_sec;
  int s_year, s_month, s_day, s_hour, s_min, s_sec;
  int m_pre;
  bit m_pulse, m_err, m_check;
  int accepts;

  function automatic int mdays(int mo, int yr);
    int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    return tbl[mo - 1] + ((mo == 2 && (yr % 4) == 0) ? 1 : 0);
  endfunction

  function automatic bit staged_ok();
    if (s_sec > 59 || s_min > 59 || s_hour > 23) return 0;
    if (s_month < 1 || s_month > 12) return 0;
    if (s_year < 2000 || s_year > 2099) return 0;
    if (s_day < 1 || s_day > mdays(s_month, s_year)) return 0;
    return 1;
  endfunction

  task automatic m_advance();
    m_sec++;
    if (m_sec == 60) begin
      m_sec = 0; m_min++;
      if (m_min == 60) begin
        m_min = 0; m_hour++;
        if (m_hour == 24) begin
          m_hour = 0; m_day++;
          if (m_day > mdays(m_month, m_year)) begin
            m_day = 1; m_month++;
            if (m_month == 13) begin
              m_month = 1; m_year++;
              if (m_year == 2100) m_year = 2000;
            end
          end
        end
      end
    end
  endtask

  task automatic model_reset();
    m_year = 2000; m_month = 1; m_day = 1;
    m_hour = 0; m_min = 0; m_sec = 0;
    m_pre = 0; m_pulse = 0; m_err = 0; m_check = 0;
  endtask

  function automatic logic [40:0] model_vec();
    return {12'(m_year), 4'(m_month), 5'(m_day), 5'(m_hour), 6'(m_min),
            6'(m_sec), m_pulse, m_err, ~m_check};
  endfunction

  wire [40:0] obs_vec = {year, month, day, hours, minutes, seconds,
                         sec_pulse, set_err, set_ready};

  // ---------------- driver tasks ----------------
  // One clock edge: model consumes the inputs held since the last negedge.
  task automatic cyc();
    bit was_check, tick;
    @(posedge clk);
    was_check = m_check;
    tick = en && (m_pre == N - 1) && !was_check;
    m_pulse = tick;
    m_err = 0;
    if (was_check && staged_ok()) begin
      m_year = s_year; m_month = s_month; m_day = s_day;
      m_hour = s_hour; m_min = s_min; m_sec = s_sec;
      m_pre = 0;
    end else begin
      if (was_check) m_err = 1;
      if (en) m_pre = (m_pre + 1) % N;
      if (tick) m_advance();
    end
    if (!was_check && set_valid) begin
      s_year = set_year; s_month = set_month; s_day = set_day;
      s_hour = set_hour; s_min = set_min; s_sec = set_sec;
      m_check = 1;
      accepts++;
    end else begin
      m_check = 0;
    end
    @(negedge clk);
  endtask

  task automatic drive_fields(int yr, int mo, int d, int h, int mi, int s);
    set_year = 12'(yr); set_month = 4'(mo); set_day = 5'(d);
    set_hour = 5'(h); set_min = 6'(mi); set_sec = 6'(s);
  endtask

  // Accept edge followed by the CHECK/load edge.
  task automatic do_set(int yr, int mo, int d, int h, int mi, int s);
    drive_fields(yr, mo, d, h, mi, s);
    set_valid = 1'b1;
    cyc();
    set_valid = 1'b0;
    cyc();
  endtask

  // Steps until a seconds strobe, bounded; reports whether one arrived.
  task automatic run_to_tick(output bit got);
    got = 0;
    for (int i = 0; i < 2 * N + 2; i++) begin
      cyc();
      if (sec_pulse) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    set_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (obs_vec !== model_vec()) begin
      n_errors++;
      $display("FAIL reset_vec: got %h required %h", obs_vec, model_vec());
    end
    n_checks++;
    if ({year, month, day} !== {12'd2000, 4'd1, 5'd1}) begin
      n_errors++;
      $display("FAIL reset_date: got %0d-%0d-%0d required 2000-1-1", year, month, day);
    end
    n_checks++;
    if ({set_ready, sec_pulse, set_err} !== 3'b100) begin
      n_errors++;
      $display("FAIL reset_flags: got %b required 100", {set_ready, sec_pulse, set_err});
    end
  endtask

  task automatic test_cadence();
    en = 1'b1;
    apply_reset();
    for (int c = 1; c <= 12; c++) begin
      cyc();
      n_checks++;
      if (sec_pulse !== ((c % N) == 0)) begin
        n_errors++;
        $display("FAIL cadence_pulse c=%0d: got %b required %b", c, sec_pulse, (c % N) == 0);
      end
      n_checks++;
      if (obs_vec !== model_vec()) begin
        n_errors++;
        $display("FAIL cadence_vec c=%0d: got %h required %h", c, obs_vec, model_vec());
      end
      if (c == 4) begin
        n_checks++;
        if (seconds !== 6'd1) begin
          n_errors++;
          $display("FAIL cadence_first_sec: got %0d required 1", seconds);
        end
      end
    end
  endtask

  task automatic check_rollover(string name, int yr, int mo, int d,
                                int ryr, int rmo, int rd);
    bit got;
    en = 1'b1;
    do_set(yr, mo, d, 23, 59, 59);
    n_checks++;
    if ({year, month, day, hours, minutes, seconds} !==
        {12'(yr), 4'(mo), 5'(d), 5'd23, 6'd59, 6'd59}) begin
      n_errors++;
      $display("FAIL %s_load: got %0d-%0d-%0d %0d:%0d:%0d", name,
               year, month, day, hours, minutes, seconds);
    end
    run_to_tick(got);
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL %s_tick: got no sec_pulse required one within %0d cycles", name, 2 * N + 2);
    end
    n_checks++;
    if ({year, month, day, hours, minutes, seconds} !==
        {12'(ryr), 4'(rmo), 5'(rd), 5'd0, 6'd0, 6'd0}) begin
      n_errors++;
      $display("FAIL %s_roll: got %0d-%0d-%0d %0d:%0d:%0d required %0d-%0d-%0d 0:0:0",
               name, year, month, day, hours, minutes, seconds, ryr, rmo, rd);
    end
    n_checks++;
    if (obs_vec !== model_vec()) begin
      n_errors++;
      $display("FAIL %s_vec: got %h required %h", name, obs_vec, model_vec());
    end
  endtask

  task automatic test_rollovers();
    check_rollover("century", 2099, 12, 31, 2000, 1, 1);
    check_rollover("leap", 2024, 2, 28, 2024, 2, 29);
    check_rollover("nonleap", 2023, 2, 28, 2023, 3, 1);
  endtask

  task automatic test_bad_set();
    en = 1'b0;
    do_set(2024, 5, 5, 10, 20, 30);
    drive_fields(2024, 4, 31, 1, 2, 3);
    set_valid = 1'b1;
    cyc();
    set_valid = 1'b0;
    n_checks++;
    if ({set_ready, set_err} !== 2'b00) begin
      n_errors++;
      $display("FAIL bad_check_state: got ready,err=%b required 00", {set_ready, set_err});
    end
    cyc();
    n_checks++;
    if (set_err !== 1'b1) begin
      n_errors++;
      $display("FAIL bad_err_pulse: got %b required 1", set_err);
    end
    n_checks++;
    if ({year, month, day, hours, minutes, seconds} !==
        {12'd2024, 4'd5, 5'd5, 5'd10, 6'd20, 6'd30}) begin
      n_errors++;
      $display("FAIL bad_unchanged: got %0d-%0d-%0d %0d:%0d:%0d required 2024-5-5 10:20:30",
               year, month, day, hours, minutes, seconds);
    end
    cyc();
    n_checks++;
    if (set_err !== 1'b0 || obs_vec !== model_vec()) begin
      n_errors++;
      $display("FAIL bad_err_width: got %h required %h", obs_vec, model_vec());
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] pattern;
    int acc0;
    en = 1'b0;
    acc0 = accepts;
    drive_fields(2030, 6, 15, 12, 0, 0);
    set_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pattern[2 - i] = set_ready;
      cyc();
    end
    set_valid = 1'b0;
    cyc();
    n_checks++;
    if (pattern !== 3'b101) begin
      n_errors++;
      $display("FAIL b2b_ready: got %b required 101", pattern);
    end
    n_checks++;
    if (accepts - acc0 != 2) begin
      n_errors++;
      $display("FAIL b2b_accepts: got %0d required 2", accepts - acc0);
    end
    n_checks++;
    if (obs_vec !== model_vec()) begin
      n_errors++;
      $display("FAIL b2b_vec: got %h required %h", obs_vec, model_vec());
    end
  endtask

  task automatic test_reset_mid_check();
    en = 1'b1;
    drive_fields(2050, 7, 4, 8, 9, 10);
    set_valid = 1'b1;
    cyc();
    set_valid = 1'b0;
    n_checks++;
    if (set_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_in_check: got ready %b required 0", set_ready);
    end
    rst_n = 1'b0;
    #2;
    model_reset();
    n_checks++;
    if ({year, month, day, hours, minutes, seconds, set_err, set_ready} !==
        {12'd2000, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL midrst_values: got %h required %h", obs_vec, model_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (set_err !== 1'b0 || obs_vec !== model_vec()) begin
        n_errors++;
        $display("FAIL midrst_after i=%0d: got %h required %h", i, obs_vec, model_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      en = ($urandom_range(0, 9) < 8);
      set_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 1) begin
        drive_fields($urandom_range(2000, 2099), $urandom_range(1, 12),
                     $urandom_range(26, 31), $urandom_range(22, 23),
                     $urandom_range(58, 59), $urandom_range(50, 59));
      end else begin
        drive_fields($urandom_range(1990, 2110), $urandom_range(0, 15),
                     $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 63), $urandom_range(0, 63));
      end
      cyc();
      n_checks++;
      if (obs_vec !== model_vec()) begin
        n_errors++;
        $display("FAIL random c=%0d: got %h required %h", c, obs_vec, model_vec());
      end
    end
    set_valid = 1'b0;
  endtask

  initial begin
    accepts = 0;
    model_reset();
    s_year = 0; s_month = 0; s_day = 0; s_hour = 0; s_min = 0; s_sec = 0;
    test_reset();
    test_cadence();
    test_rollovers();
    test_bad_set();
    test_back_to_back();
    test_reset_mid_check();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/time_date_counter.md
TIME_DATE_COUNTER -- requirements
Module: time_date_counter

Interface
REQ-001 SHALL have parameter: CLK_FREQ_HZ, 50_000_000, clk cycles per second; legal range is >= 2.
REQ-002 SHALL have ports: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have ports: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports: en  input  1  run enable; when low, the prescaler and all counters hold.
REQ-005 SHALL have ports: set_valid  input  1  set request; set_ready  output  1  request accepted when both are high.
REQ-006 SHALL have ports: set_sec/set_min  input  6 each; set_hour/set_day  input  5 each; set_month  input  4; set_year  input  12.
REQ-007 SHALL have ports: seconds/minutes  output  6 each; hours/day  output  5 each; month  output  4; year  output  12; all binary, registered.
REQ-008 SHALL have ports: sec_pulse  output  1  one-cycle strobe on each seconds advance; set_err  output  1  one-cycle strobe on a rejected set.

Function
REQ-009 SHALL run a prescaler 0..CLK_FREQ_HZ-1 while en=1 and assert an internal tick on the cycle it equals CLK_FREQ_HZ-1, then wrap to 0.
REQ-010 SHALL, on tick, increment seconds and assert sec_pulse in the same cycle the registered outputs update.
REQ-011 SHALL cascade rollovers in one cycle: sec 59->0 carries to min; min 59->0 to hour; hour 23->0 to day; day at days_in_month->1 to month; month 12->1 to year; year 2099->2000.
REQ-012 SHALL use days_in_month = 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 29 for February when year[1:0]==0, else 28 (valid for 2000..2099).
REQ-013 SHALL drive set_ready=1 in IDLE; an accepted set moves to CHECK with set_ready=0 and set fields captured in a staging register.
REQ-014 SHALL in CHECK validate sec<=59, min<=59, hour<=23, 1<=month<=12, 1<=day<=days_in_month(staged month, staged year), 2000<=year<=2099.
REQ-015 SHALL on the CHECK->IDLE edge load all outputs from staging and clear the prescaler to 0 if valid; otherwise pulse set_err and leave time unchanged.
REQ-016 SHALL suppress any tick occurring while in CHECK and on the load edge; a suppressed tick is lost and not replayed.
REQ-017 SHALL ignore set input changes while set_ready=0; a request held high is re-accepted in the following IDLE cycle.
REQ-018 SHALL perform set handling independently of en, so sets are accepted while the clock is stopped.
REQ-019 SHALL hold the prescaler value when en falls and resume counting from it when en rises.

Reset
REQ-020 SHALL on rst_n low asynchronously set seconds=0, minutes=0, hours=0, day=1, month=1, year=2000, prescaler=0, FSM=IDLE, set_ready=1, sec_pulse=0 and set_err=0.
REQ-021 SHALL discard any staged set when reset is asserted mid-CHECK, with no load and no set_err.

Structure
REQ-022 SHALL place field widths, the YEAR_MIN=2000/YEAR_MAX=2099 constants, the FSM state encoding and the days_in_month function in the shared clock package.
REQ-023 SHALL isolate the prescaler in one sub-module, tick_prescaler, with ports clk, rst_n, en, clr and tick.

Verification (CLK_FREQ_HZ=4)
REQ-024 SHALL cover: reset released, en=1 -> sec_pulse every 4th cycle; seconds reaches 1 on the 4th cycle after reset release.
REQ-025 SHALL cover: set 2099-12-31 23:59:59, one tick -> 2000-01-01 00:00:00 in a single update.
REQ-026 SHALL cover: set 2024-02-28 23:59:59 then a tick -> 2024-02-29; set 2023-02-28 23:59:59 then a tick -> 2023-03-01.
REQ-027 SHALL cover: set day=31 month=4 -> set_err pulses one cycle after acceptance and outputs are unchanged.
REQ-028 SHALL cover: set_valid held 3 cycles -> set_ready pattern 1,0,1 and exactly two accepts.
REQ-029 SHALL cover: rst_n low during CHECK -> outputs at reset values with no set_err.
